// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Flow-controlled pipeline stage register with a 2-entry skid buffer.
//   It carries a payload plus a control-enable field between two CPU stages.
//   in_ready comes straight from a flop, so a downstream stall never becomes
//   a combinational path back upstream. flush kills held beats. A saturating
//   counter tracks stalled cycles.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   upstream handshake; in_data/in_ctrl sampled on accept
//   out_valid/ready  downstream handshake; out_data/out_ctrl are the head entry
//   flush            drop all held beats and any beat offered this cycle
//   clr_stats        clear stall_cnt
//   stall_cnt        saturating count of out_valid & !out_ready cycles
module pipe_stage_reg #(
  parameter int DATA_W      = 69,
  parameter int CTRL_W      = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  input  logic                   flush,
  input  logic                   clr_stats,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  // Occupancy encoded as {main_v, skid_v}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  beat_t      main_q, skid_q, in_beat;
  logic       main_v, skid_v;
  logic [1:0] st;
  logic       accept, drain;

  assign in_beat = '{data: in_data, ctrl: in_ctrl};
  assign st      = {main_v, skid_v};

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q.data;
  // Bubbles must never leak write enables downstream.
  assign out_ctrl  = main_q.ctrl & {CTRL_W{main_v}};

  assign accept = in_valid & in_ready;
  assign drain  = main_v & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Only the valid bits drop; stale payload is masked by out_ctrl gating.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (accept) begin
            main_q <= in_beat;
            main_v <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_q <= in_beat;
          end else if (accept) begin
            skid_q <= in_beat;
            skid_v <= 1'b1;
          end else if (drain) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (drain) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding; fall back to empty rather than lock up.
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A queue-based reference model
// tracks accepted beats; each drain is popped and compared in order.
module tb_pipe_stage_reg;

  localparam int DW = 69;
  localparam int CW = 4;
  localparam int SW = 4;
  localparam logic [SW-1:0] SMAX = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush = 1'b0;
  logic          clr_stats = 1'b0;
  logic [SW-1:0] stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  beat_t         q[$];
  logic [SW-1:0] exp_stall = '0;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_out = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs against the model for the current cycle, advance the
  // model by one edge, then compare the registered stall counter.
  task automatic tick();
    int n;
    bit acc, drn;
    n = q.size();
    if (chk_en) begin
      chk("in_ready", in_ready, n < 2);
      chk("out_valid", out_valid, n > 0);
      if (n > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_ctrl", out_ctrl, q[0].ctrl);
      end else begin
        chk("out_ctrl_bubble", out_ctrl, 0);
      end
    end
    acc = in_valid && (n < 2);
    drn = (n > 0) && out_ready;
    if (drn) begin
      void'(q.pop_front());
      n_out++;
    end
    if (rst || clr_stats) exp_stall = '0;
    else if (n > 0 && !out_ready && exp_stall != SMAX) exp_stall = exp_stall + 1'b1;
    if (rst || flush) q.delete();
    else if (acc) q.push_back({in_data, in_ctrl});
    @(posedge clk);
    #1;
    if (chk_en) chk("stall_cnt", stall_cnt, exp_stall);
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    tick();
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    // Initial reset brings outputs out of X before checking starts.
    tick();
    chk_en = 1'b1;

    // Reset with a beat offered: nothing captured.
    in_valid = 1'b1;
    in_data  = DW'(8'h1F);
    in_ctrl  = 4'hF;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    idle(2);

    // Streaming 0..7, one beat per cycle.
    out_ready = 1'b1;
    n_out = 0;
    for (int i = 0; i < 8; i++) offer(DW'(i), 4'b1010);
    idle(2);
    chk("stream_count", n_out, 8);

    // Skid fill: A held, B to skid, C refused until space frees.
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    out_ready = 1'b0;
    n_out = 0;
    offer(DW'(8'h11), 4'b0001);
    offer(DW'(8'h22), 4'b0010);
    offer(DW'(8'h33), 4'b0100);
    chk("skid_in_ready", in_ready, 0);
    tick();
    chk("skid_stalls", stall_cnt, 3);
    out_ready = 1'b1;
    tick();
    tick();
    idle(2);
    chk("skid_count", n_out, 3);

    // Flush in FULL with a beat offered; D must never appear.
    out_ready = 1'b0;
    offer(DW'(8'h11), 4'b1111);
    offer(DW'(8'h22), 4'b1111);
    in_data = DW'(8'h44);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    offer(DW'(8'h55), 4'b0011);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_data", out_data, DW'(8'h55));
    idle(1);

    // Flush in ONE with an accepted-but-discarded beat.
    out_ready = 1'b0;
    offer(DW'(8'h66), 4'b1000);
    in_data = DW'(8'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(2);

    // Flush with concurrent drain: head delivered, then empty.
    out_ready = 1'b1;
    n_out = 0;
    offer(DW'(8'h88), 4'b0101);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_drain_count", n_out, 1);
    chk("flush_drain_empty", out_valid, 0);
    idle(1);

    // Counter saturation and clear during a stall.
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    out_ready = 1'b0;
    offer(DW'(8'h99), 4'b0110);
    idle(20);
    chk("stall_sat", stall_cnt, 15);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk("stall_clr", stall_cnt, 0);
    tick();
    chk("stall_after_clr", stall_cnt, 1);
    out_ready = 1'b1;
    idle(2);

    // Reset mid-operation loses held beats; next beat has 1-cycle latency.
    out_ready = 1'b0;
    offer(DW'(8'hA1), 4'b0001);
    offer(DW'(8'hA2), 4'b0010);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    out_ready = 1'b1;
    offer(DW'(8'hB1), 4'b1001);
    chk("midrst_latency", out_data, DW'(8'hB1));
    idle(1);

    // Random traffic with occasional flush and clear.
    for (int i = 0; i < 300; i++) begin
      logic [DW-1:0] r;
      r = {$urandom, $urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = r;
      in_ctrl   = CW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      clr_stats = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("final_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that generalises the fixed EXE/MEM latch. It carries an arbitrary-width payload plus a control-enable field (wreg/wmem/m2reg/branch-style strobes) between any two CPU stages. It adds a valid/ready handshake with a 2-entry skid buffer, so stalls do not create a combinational ready path, and a flush input that kills in-flight beats on a taken branch or exception. A saturating stall counter supports performance debug.

## Interface
- DATA_W, 69: payload width (default = alu 32 + b 32 + rn 5).
- CTRL_W, 4: control-enable width; these bits are forced to 0 whenever the stage holds a bubble.
- STALL_CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control enables.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  head control enables, gated by out_valid.
- flush  in  1  kill all held beats and any beat offered this cycle.
- clr_stats  in  1  clear stall_cnt.
- stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- Storage: main entry (main_v, main_data, main_ctrl) and skid entry (skid_v, skid_data, skid_ctrl).
- States: EMPTY (main_v=0, skid_v=0), ONE (1,0), FULL (1,1). (0,1) is illegal and must never occur.
- accept = in_valid & in_ready. drain = out_valid & out_ready.
- in_ready = !skid_v. out_valid = main_v. out_data = main_data. out_ctrl = main_v ? main_ctrl : 0.
- EMPTY: accept -> ONE, main <= in.
- ONE: accept & drain -> ONE, main <= in. accept & !drain -> FULL, skid <= in. !accept & drain -> EMPTY. Neither -> hold.
- FULL: drain -> ONE, main <= skid, skid_v <= 0. No accept is possible because in_ready=0. No drain -> hold.
- Ordering is strictly FIFO. A beat in skid is never overtaken.
- flush has the highest priority. Next state is EMPTY regardless of accept or drain. A beat offered with in_valid & in_ready in the flush cycle completes its handshake upstream but is discarded. A beat draining in the flush cycle is still delivered downstream in that cycle, since the handshake is already complete.
- Data and ctrl registers are not cleared by flush. Only the valid bits are cleared; out_ctrl gating guarantees no write side effects.
- stall_cnt: +1 each cycle with out_valid & !out_ready. It saturates at 2^STALL_CNT_W-1, with no wrap. clr_stats sets it to 0 next cycle and takes priority over increment. flush does not affect stall_cnt.
- rst: main_v, skid_v, all data and ctrl registers, and stall_cnt go to 0. rst overrides flush, clr_stats and any handshake in the same cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
- Latency: a beat accepted at edge N into EMPTY is visible on out_* after edge N (one cycle). A beat accepted into skid appears on out_* one cycle after the head drains.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready falls in the cycle after the skid fills, and rises in the cycle after the skid moves to main. It has no combinational dependence on out_ready, in_valid or flush.
- out_valid and out_data are register outputs. out_ctrl is one AND level on registers.
- Upstream rule: in_data and in_ctrl are sampled only on accept. in_valid may drop without a handshake; the stage does not require it to stay asserted.
- Reset mid-operation: held beats are lost with no output. The first post-reset beat takes one-cycle latency.

## Test plan
- Reset / idle: assert rst 2 cycles with in_valid=1 and in_data=0x1F -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0; nothing is captured.
- Streaming: 8 back-to-back beats with data 0..7 and ctrl 4'b1010, out_ready=1 -> out_valid from cycle 1, data 0..7 on consecutive cycles, in_ready stays 1.
- Skid fill / drain: beats A=0x11, B=0x22, C=0x33 with out_ready=0 -> A held, B in skid, in_ready=0 after B, C not accepted. Raise out_ready -> output order A, B, C with no loss or duplication. stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush in FULL: hold A, B, assert flush for 1 cycle with in_valid=1 and D=0x44 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D is never output. A subsequent E=0x55 appears after 1 cycle.
- Flush with concurrent drain: ONE state with out_ready=1 and flush=1 -> the head beat is delivered in that cycle and the stage is EMPTY afterwards.
- Counter saturation / clear: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds. Pulse clr_stats during a stall -> 0 next cycle, then 1.
